kamus_wb_stage: RTL

Parametrised writeback stage for the kamus core. It replaces the purely combinational WB mux with a registered MEM/WB stage that accepts instructions over a valid/ready handshake. It stalls on outstanding L1D load responses, aligns and sign-extends load data, drops flushed instructions, and times out lost responses. It sits between the MEM stage and the register file, and also drives the branch-redirect interface back to IF.

---
 rtl/kamus_pkg.sv | 36 +++
 rtl/kamus_wb_load_align.sv | 30 +++
 rtl/kamus_wb_stage.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/kamus_pkg.sv
// Shared types for the kamus core writeback path: result select, load size and
// writeback FSM states, plus the misaligned-load rule used at accept time.
package kamus_pkg;

   typedef enum logic [1:0] {
      ALU_RESULT = 2'b00,
      MEM_RESULT = 2'b01,
      NEXT_PC    = 2'b10
   } wb_options_e;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } ld_size_e;

   typedef enum logic [1:0] {
      IDLE     = 2'b00,
      WAIT_MEM = 2'b01,
      DRAIN    = 2'b10
   } wb_state_e;

   // Halfwords need an even byte lane, words need lane 0.
   function automatic logic ld_misaligned(input logic [2:0] size, input logic [1:0] lane);
      logic mis;
      case (size)
         LH, LHU: mis = lane[0];
         LW:      mis = (lane != 2'b00);
         default: mis = 1'b0;
      endcase
      return mis;
   endfunction

endpackage

// File: rtl/kamus_wb_load_align.sv
// Load data extraction: selects the byte/halfword lane from the L1D word and
// applies sign or zero extension according to the load funct3.
module kamus_wb_load_align
   import kamus_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      ld_size,
   input  logic [1:0]      addr,
   input  logic [XLEN-1:0] rdata,
   output logic [XLEN-1:0] ld_data
);

   logic [XLEN-1:0] shifted_s;

   // Lane select by shifting the addressed byte down to bit 0, then extend.
   always_comb begin
      shifted_s = rdata >> {addr, 3'b000};
      ld_data   = '0;
      case (ld_size_e'(ld_size))
         LB:      ld_data = {{(XLEN-8){shifted_s[7]}}, shifted_s[7:0]};
         LH:      ld_data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
         LW:      ld_data = rdata;
         LBU:     ld_data = {{(XLEN-8){1'b0}}, shifted_s[7:0]};
         LHU:     ld_data = {{(XLEN-16){1'b0}}, shifted_s[15:0]};
         default: ld_data = '0;
      endcase
   end

endmodule

// File: rtl/kamus_wb_stage.sv
// Registered MEM/WB stage with load-response wait, flush drain and timeout.
// Optional EX bypass ports are enabled by defining KAMUS_WB_FWD_EN.
module kamus_wb_stage
   import kamus_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int REG_AW      = 5,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic              regfile_wr_en_i,
   input  logic [1:0]        wb_mux_sel_i,
   input  logic [2:0]        ld_size_i,
   input  logic [XLEN-1:0]   ex_rslt_i,
   input  logic [XLEN-1:0]   next_pc_i,
   input  logic [REG_AW-1:0] rd_addr_i,
   input  logic              is_branch_taken_i,
   input  logic              flush_i,
   input  logic              l1d_rsp_valid_i,
   input  logic [XLEN-1:0]   l1d_rd_data_i,
   output logic              regfile_wr_en_o,
   output logic [REG_AW-1:0] rd_addr_o,
   output logic [XLEN-1:0]   wb_data_o,
   output logic              is_branch_taken_o,
   output logic [XLEN-1:0]   ex_rslt_o,
   output logic              misalign_o,
`ifdef KAMUS_WB_FWD_EN
   output logic              fwd_valid_o,
   output logic [REG_AW-1:0] fwd_rd_o,
   output logic [XLEN-1:0]   fwd_data_o,
`endif
   output logic              timeout_o
);

   localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

   wb_state_e         state_r, state_nxt_s;
   logic [CNT_W-1:0]  cnt_r, cnt_nxt_s;
   logic [2:0]        ld_size_r;
   logic [1:0]        lane_r;
   logic [REG_AW-1:0] rd_r;
   logic              wr_en_r;

   logic              accept_s, is_load_s, misalign_s, timeout_hit_s;
   logic              wr_en_nxt_s, misalign_nxt_s, timeout_nxt_s;
   logic [REG_AW-1:0] wr_rd_nxt_s;
   logic [XLEN-1:0]   wr_data_nxt_s, ld_data_s;

   assign ready_o       = (state_r == IDLE);
   assign accept_s      = valid_i & ready_o & ~flush_i;
   assign is_load_s     = (wb_mux_sel_i == MEM_RESULT);
   assign misalign_s    = ld_misaligned(ld_size_i, ex_rslt_i[1:0]);
   assign timeout_hit_s = (TIMEOUT_CYC != 0) && (cnt_r == CNT_W'(TIMEOUT_CYC - 1));

   kamus_wb_load_align #(.XLEN(XLEN)) u_align (
      .ld_size (ld_size_r),
      .addr    (lane_r),
      .rdata   (l1d_rd_data_i),
      .ld_data (ld_data_s)
   );

   // Next-state, wait counter and next values of the registered outputs.
   always_comb begin
      state_nxt_s    = state_r;
      cnt_nxt_s      = cnt_r;
      wr_en_nxt_s    = 1'b0;
      wr_rd_nxt_s    = rd_addr_o;
      wr_data_nxt_s  = wb_data_o;
      misalign_nxt_s = 1'b0;
      timeout_nxt_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s && is_load_s) begin
               if (misalign_s) begin
                  misalign_nxt_s = 1'b1;
               end else begin
                  state_nxt_s = WAIT_MEM;
                  cnt_nxt_s   = '0;
               end
            end else if (accept_s && regfile_wr_en_i && (rd_addr_i != '0)) begin
               wr_en_nxt_s = 1'b1;
               wr_rd_nxt_s = rd_addr_i;
               case (wb_mux_sel_i)
                  ALU_RESULT: wr_data_nxt_s = ex_rslt_i;
                  NEXT_PC:    wr_data_nxt_s = next_pc_i;
                  default:    wr_data_nxt_s = '0;
               endcase
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WAIT_MEM: begin
            if (l1d_rsp_valid_i) begin
               state_nxt_s = IDLE;
               if (!flush_i && wr_en_r && (rd_r != '0)) begin
                  wr_en_nxt_s   = 1'b1;
                  wr_rd_nxt_s   = rd_r;
                  wr_data_nxt_s = ld_data_s;
               end else begin
                  wr_en_nxt_s = 1'b0;
               end
            end else if (flush_i) begin
               state_nxt_s = DRAIN;
               cnt_nxt_s   = '0;
            end else if (timeout_hit_s) begin
               state_nxt_s   = IDLE;
               timeout_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (l1d_rsp_valid_i) begin
               state_nxt_s = IDLE;
            end else if (timeout_hit_s) begin
               state_nxt_s   = IDLE;
               timeout_nxt_s = 1'b1;
            end else begin
               cnt_nxt_s = cnt_r + CNT_W'(1);
            end
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // State and wait counter registers.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_r <= IDLE;
         cnt_r   <= '0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
      end
   end

   // Registered outputs plus the load context latched at accept.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         regfile_wr_en_o   <= 1'b0;
         rd_addr_o         <= '0;
         wb_data_o         <= '0;
         is_branch_taken_o <= 1'b0;
         ex_rslt_o         <= '0;
         misalign_o        <= 1'b0;
         timeout_o         <= 1'b0;
         ld_size_r         <= 3'b000;
         lane_r            <= 2'b00;
         rd_r              <= '0;
         wr_en_r           <= 1'b0;
      end else begin
         regfile_wr_en_o   <= wr_en_nxt_s;
         rd_addr_o         <= wr_rd_nxt_s;
         wb_data_o         <= wr_data_nxt_s;
         is_branch_taken_o <= accept_s & is_branch_taken_i;
         ex_rslt_o         <= accept_s ? ex_rslt_i : '0;
         misalign_o        <= misalign_nxt_s;
         timeout_o         <= timeout_nxt_s;
         if (accept_s) begin
            ld_size_r <= ld_size_i;
            lane_r    <= ex_rslt_i[1:0];
            rd_r      <= rd_addr_i;
            wr_en_r   <= regfile_wr_en_i;
         end
      end
   end

`ifdef KAMUS_WB_FWD_EN
   assign fwd_valid_o = regfile_wr_en_o;
   assign fwd_rd_o    = rd_addr_o;
   assign fwd_data_o  = wb_data_o;
`endif

endmodule
